// File: rtl/iommu_msi_ig.sv
// MSI interrupt generator: turns CQ/FQ/HPM interrupt-pending edges into
// single-beat 32-bit AXI writes using the MSI config table entry that each
// source's vector selects. AW is always issued strictly before W.
module iommu_msi_ig #(
    parameter  int N_INT_VEC = 16,
    localparam int LOG2_VEC  = $clog2(N_INT_VEC)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          msi_en_i,
    input  logic                          cq_ip_i,
    input  logic                          fq_ip_i,
    input  logic                          hpm_ip_i,
    input  logic [LOG2_VEC-1:0]           civ_i,
    input  logic [LOG2_VEC-1:0]           fiv_i,
    input  logic [LOG2_VEC-1:0]           pmiv_i,
    input  logic [N_INT_VEC-1:0][63:0]    msi_addr_i,
    input  logic [N_INT_VEC-1:0][31:0]    msi_data_i,
    input  logic [N_INT_VEC-1:0]          msi_mask_i,
    // AW channel
    output logic [3:0]                    mem_aw_id_o,
    output logic [63:0]                   mem_aw_addr_o,
    output logic [7:0]                    mem_aw_len_o,
    output logic [2:0]                    mem_aw_size_o,
    output logic [1:0]                    mem_aw_burst_o,
    output logic                          mem_aw_lock_o,
    output logic [3:0]                    mem_aw_cache_o,
    output logic [2:0]                    mem_aw_prot_o,
    output logic [3:0]                    mem_aw_qos_o,
    output logic [3:0]                    mem_aw_region_o,
    output logic [5:0]                    mem_aw_atop_o,
    output logic                          mem_aw_valid_o,
    input  logic                          mem_aw_ready_i,
    // W channel
    output logic [63:0]                   mem_w_data_o,
    output logic [7:0]                    mem_w_strb_o,
    output logic                          mem_w_last_o,
    output logic                          mem_w_valid_o,
    input  logic                          mem_w_ready_i,
    // B channel
    input  logic                          mem_b_valid_i,
    input  logic [1:0]                    mem_b_resp_i,
    output logic                          mem_b_ready_o,
    // AR/R channels are never used by this requester
    output logic                          mem_ar_valid_o,
    output logic [63:0]                   mem_ar_addr_o,
    output logic                          mem_r_ready_o,
    output logic                          msi_err_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t        state_q, state_d;
    logic [2:0]    ip_q, pend_q, rise, elig, clr;
    logic [1:0]    sel_q, gnt_src;
    logic [63:0]   addr_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic          gnt_valid, start, b_done;
    logic [LOG2_VEC-1:0] gnt_vec;

    // Source bit order: 0 = CQ, 1 = FQ, 2 = HPM (also the priority order)
    assign rise   = {hpm_ip_i, fq_ip_i, cq_ip_i} & ~ip_q;
    assign elig   = pend_q & ~{msi_mask_i[pmiv_i], msi_mask_i[fiv_i], msi_mask_i[civ_i]};
    assign start  = (state_q == IDLE) && msi_en_i && gnt_valid;
    assign b_done = (state_q == B) && mem_b_valid_i;
    assign clr    = b_done ? (3'b001 << sel_q) : 3'b000;

    // Fixed-priority pick among pending sources whose vector is unmasked
    always_comb begin
        gnt_valid = 1'b1;
        gnt_src   = 2'd0;
        gnt_vec   = civ_i;
        if (elig[0]) begin
            gnt_src = 2'd0;
            gnt_vec = civ_i;
        end else if (elig[1]) begin
            gnt_src = 2'd1;
            gnt_vec = fiv_i;
        end else if (elig[2]) begin
            gnt_src = 2'd2;
            gnt_vec = pmiv_i;
        end else begin
            gnt_valid = 1'b0;
        end
    end

    // Edge capture, pending bits, latched transaction payload, error pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_q   <= '0;
            pend_q <= '0;
            sel_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ip_q  <= {hpm_ip_i, fq_ip_i, cq_ip_i};
            err_q <= b_done && (mem_b_resp_i != 2'b00);
            // Disabled while idle: drop whatever is still queued. A pend bit
            // only clears at B, so repeat edges on an in-flight source merge.
            if (state_q == IDLE && !msi_en_i)
                pend_q <= '0;
            else
                pend_q <= (pend_q & ~clr) | (rise & {3{msi_en_i}});
            if (start) begin
                sel_q  <= gnt_src;
                addr_q <= msi_addr_i[gnt_vec];
                data_q <= msi_data_i[gnt_vec];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state: one write per pass, W only after the AW handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)          state_d = AW;
            AW:   if (mem_aw_ready_i) state_d = W;
            W:    if (mem_w_ready_i)  state_d = B;
            B:    if (mem_b_valid_i)  state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // FSM outputs; payload is zero whenever its channel is not valid
    always_comb begin
        mem_aw_id_o     = 4'b0000;
        mem_aw_addr_o   = '0;
        mem_aw_len_o    = 8'd0;
        mem_aw_size_o   = 3'b000;
        mem_aw_burst_o  = 2'b00;
        mem_aw_lock_o   = 1'b0;
        mem_aw_cache_o  = 4'b0000;
        mem_aw_prot_o   = 3'b000;
        mem_aw_qos_o    = 4'b0000;
        mem_aw_region_o = 4'b0000;
        mem_aw_atop_o   = 6'b000000;
        mem_aw_valid_o  = 1'b0;
        mem_w_data_o    = '0;
        mem_w_strb_o    = 8'h00;
        mem_w_last_o    = 1'b0;
        mem_w_valid_o   = 1'b0;
        mem_b_ready_o   = 1'b0;
        mem_ar_valid_o  = 1'b0;
        mem_ar_addr_o   = '0;
        mem_r_ready_o   = 1'b0;
        busy_o          = (state_q != IDLE);
        msi_err_o       = err_q;
        case (state_q)
            AW: begin
                mem_aw_valid_o = 1'b1;
                mem_aw_id_o    = 4'b0010;
                mem_aw_addr_o  = addr_q & ~64'd3;
                mem_aw_size_o  = 3'b010;
                mem_aw_burst_o = 2'b01;
            end
            W: begin
                mem_w_valid_o = 1'b1;
                mem_w_last_o  = 1'b1;
                // 32-bit data goes into the lane selected by address bit 2
                if (addr_q[2]) begin
                    mem_w_data_o = {data_q, 32'h0};
                    mem_w_strb_o = 8'hF0;
                end else begin
                    mem_w_data_o = {32'h0, data_q};
                    mem_w_strb_o = 8'h0F;
                end
            end
            B:       mem_b_ready_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iommu_msi_ig.sv
// Directed bench for iommu_msi_ig: acts as the AXI slave on the IG port and
// checks each write against hand-computed address/data/strobe values.
module tb_iommu_msi_ig;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              msi_en = 1'b1;
    logic              cq_ip = 1'b0, fq_ip = 1'b0, hpm_ip = 1'b0;
    logic [3:0]        civ = '0, fiv = '0, pmiv = '0;
    logic [15:0][63:0] msi_addr = '0;
    logic [15:0][31:0] msi_data = '0;
    logic [15:0]       msi_mask = '0;
    logic [3:0]        aw_id;
    logic [63:0]       aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              aw_lock;
    logic [3:0]        aw_cache;
    logic [2:0]        aw_prot;
    logic [3:0]        aw_qos;
    logic [3:0]        aw_region;
    logic [5:0]        aw_atop;
    logic              aw_valid;
    logic              aw_ready = 1'b0;
    logic [63:0]       w_data;
    logic [7:0]        w_strb;
    logic              w_last, w_valid;
    logic              w_ready = 1'b0;
    logic              b_valid = 1'b0;
    logic [1:0]        b_resp = 2'b00;
    logic              b_ready, ar_valid, r_ready, msi_err, busy;
    logic [63:0]       ar_addr;

    int checks = 0;
    int failures = 0;

    iommu_msi_ig #(.N_INT_VEC(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .msi_en_i(msi_en),
        .cq_ip_i(cq_ip), .fq_ip_i(fq_ip), .hpm_ip_i(hpm_ip),
        .civ_i(civ), .fiv_i(fiv), .pmiv_i(pmiv),
        .msi_addr_i(msi_addr), .msi_data_i(msi_data), .msi_mask_i(msi_mask),
        .mem_aw_id_o(aw_id), .mem_aw_addr_o(aw_addr), .mem_aw_len_o(aw_len),
        .mem_aw_size_o(aw_size), .mem_aw_burst_o(aw_burst), .mem_aw_lock_o(aw_lock),
        .mem_aw_cache_o(aw_cache), .mem_aw_prot_o(aw_prot), .mem_aw_qos_o(aw_qos),
        .mem_aw_region_o(aw_region), .mem_aw_atop_o(aw_atop),
        .mem_aw_valid_o(aw_valid), .mem_aw_ready_i(aw_ready),
        .mem_w_data_o(w_data), .mem_w_strb_o(w_strb), .mem_w_last_o(w_last),
        .mem_w_valid_o(w_valid), .mem_w_ready_i(w_ready),
        .mem_b_valid_i(b_valid), .mem_b_resp_i(b_resp), .mem_b_ready_o(b_ready),
        .mem_ar_valid_o(ar_valid), .mem_ar_addr_o(ar_addr), .mem_r_ready_o(r_ready),
        .msi_err_o(msi_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded waits stalls
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Count AW valid cycles over a window; expect none
    task automatic no_aw(input string tag, input int cyc);
        int seen = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (aw_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    // Serve one write as the slave, with optional AW/W ready stalls
    task automatic txn(input string tag, input logic [63:0] ea, input logic [63:0] ed,
                       input logic [7:0] es, input logic [1:0] rs,
                       input int awd, input int wd, input int maxw);
        int n = 0;
        while (!aw_valid && n < maxw) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " aw_valid"}, aw_valid, 1);
        chk({tag, " w_early"},  w_valid, 0);
        chk({tag, " aw_addr"},  aw_addr, ea);
        chk({tag, " aw_attr"},  {aw_id, aw_len, aw_size, aw_burst}, {4'h2, 8'h0, 3'b010, 2'b01});
        chk({tag, " aw_zero"},  {aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop}, 0);
        repeat (awd) begin
            @(negedge clk);
            chk({tag, " aw_hold"}, {aw_valid, w_valid, aw_addr}, {1'b1, 1'b0, ea});
        end
        aw_ready = 1'b1;
        @(negedge clk);
        aw_ready = 1'b0;
        chk({tag, " w_valid"}, {w_valid, aw_valid, w_last}, {1'b1, 1'b0, 1'b1});
        chk({tag, " w_data"},  w_data, ed);
        chk({tag, " w_strb"},  w_strb, es);
        repeat (wd) begin
            @(negedge clk);
            chk({tag, " w_hold"}, {w_valid, w_strb, w_data[31:0] | w_data[63:32]},
                {1'b1, es, ed[31:0] | ed[63:32]});
        end
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        chk({tag, " b_ready"}, {b_ready, w_valid, busy}, {1'b1, 1'b0, 1'b1});
        b_valid = 1'b1;
        b_resp  = rs;
        @(negedge clk);
        b_valid = 1'b0;
        b_resp  = 2'b00;
        chk({tag, " idle"}, busy, 0);
    endtask

    initial begin
        msi_addr[1] = 64'h0000_0000_8000_2000; msi_data[1] = 32'h1111_0001;
        msi_addr[2] = 64'h0000_0000_8000_3008; msi_data[2] = 32'h2222_0002;
        msi_addr[3] = 64'h0000_0000_8000_1004; msi_data[3] = 32'h0000_00A5;
        msi_addr[4] = 64'h0000_0000_8000_400C; msi_data[4] = 32'h4444_0004;
        msi_addr[5] = 64'h0000_0000_9000_0013; msi_data[5] = 32'h5555_0005;
        msi_addr[6] = 64'hFFFF_FFFF_0000_0020; msi_data[6] = 32'h6666_0006;

        // Reset state
        #2;
        chk("rst_out", {aw_valid, w_valid, b_ready, ar_valid, r_ready, msi_err, busy}, 0);
        chk("rst_pay", aw_addr | w_data | ar_addr, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        no_aw("idle_quiet", 3);

        // CQ via entry 3: upper lane, strobe F0
        civ = 4'd3;
        cq_ip = 1'b1;
        txn("cq3", 64'h8000_1004, 64'h0000_00A5_0000_0000, 8'hF0, 2'b00, 0, 0, 4);
        chk("cq3_err", msi_err, 0);
        no_aw("cq3_level_no_retrig", 6);
        cq_ip = 1'b0;
        @(negedge clk);

        // CQ and FQ together: CQ first, FQ in the very next transaction
        civ = 4'd1; fiv = 4'd2;
        cq_ip = 1'b1; fq_ip = 1'b1;
        txn("both_cq", 64'h8000_2000, 64'h0000_0000_1111_0001, 8'h0F, 2'b00, 0, 0, 4);
        txn("both_fq", 64'h8000_3008, 64'h0000_0000_2222_0002, 8'h0F, 2'b00, 0, 0, 1);
        no_aw("both_done", 4);
        cq_ip = 1'b0; fq_ip = 1'b0;
        @(negedge clk);

        // Masked vector holds the FQ request until unmasked
        fiv = 4'd4;
        msi_mask[4] = 1'b1;
        fq_ip = 1'b1;
        no_aw("fq_masked", 20);
        msi_mask[4] = 1'b0;
        txn("fq_unmask", 64'h8000_400C, 64'h4444_0004_0000_0000, 8'hF0, 2'b00, 0, 0, 3);
        no_aw("fq_once", 5);
        fq_ip = 1'b0;

        // HPM with ready stalls; addr bits [1:0] forced to zero
        pmiv = 4'd5;
        hpm_ip = 1'b1;
        txn("hpm_stall", 64'h9000_0010, 64'h0000_0000_5555_0005, 8'h0F, 2'b00, 5, 3, 4);
        hpm_ip = 1'b0;
        @(negedge clk);

        // SLVERR: one-cycle error pulse, no retry
        civ = 4'd6;
        cq_ip = 1'b1;
        txn("slverr", 64'hFFFF_FFFF_0000_0020, 64'h0000_0000_6666_0006, 8'h0F, 2'b10, 0, 0, 4);
        chk("err_pulse", msi_err, 1);
        @(negedge clk);
        chk("err_clear", msi_err, 0);
        no_aw("err_no_retry", 6);
        cq_ip = 1'b0;
        @(negedge clk);

        // Reset while in W
        civ = 4'd3;
        cq_ip = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_aw", aw_valid, 1);
        aw_ready = 1'b1;
        @(negedge clk);
        aw_ready = 1'b0;
        chk("rstw_in_w", w_valid, 1);
        rst_ni = 1'b0;
        #1;
        chk("rstw_out", {aw_valid, w_valid, b_ready, busy, msi_err}, 0);
        chk("rstw_pay", {w_data, w_strb} | {aw_addr, 8'h00}, 0);
        cq_ip = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        no_aw("rstw_quiet", 8);
        cq_ip = 1'b1;
        txn("rstw_new", 64'h8000_1004, 64'h0000_00A5_0000_0000, 8'hF0, 2'b00, 0, 0, 4);
        cq_ip = 1'b0;
        @(negedge clk);

        // Disable mid-transaction: current write finishes, queued FQ dropped
        civ = 4'd1; fiv = 4'd2;
        cq_ip = 1'b1; fq_ip = 1'b1;
        @(negedge clk);
        @(negedge clk);
        msi_en = 1'b0;
        txn("en_fall", 64'h8000_2000, 64'h0000_0000_1111_0001, 8'h0F, 2'b00, 2, 0, 0);
        no_aw("en_off", 4);
        msi_en = 1'b1;
        no_aw("en_fq_dropped", 6);
        cq_ip = 1'b0; fq_ip = 1'b0;

        // Edge while disabled is lost
        msi_en = 1'b0;
        @(negedge clk);
        hpm_ip = 1'b1;
        @(negedge clk);
        msi_en = 1'b1;
        no_aw("edge_while_off", 8);
        hpm_ip = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
